persiana_actuador: RTL
======================

Name: persiana_actuador

Overview:
Plant-side end of the blind controller interface. Consumes the controller's subir/bajar motor commands, drives a step/direction motor interface and tracks blind position in a step counter. Generates the three position sensors (superior, medio, inferior) that feed back into the blind FSM. Used on silicon as the motor driver front end, and in simulation as the closed-loop plant model.

Parameters:
POS_MAX, 200, full travel in steps; position 0 = fully closed, POS_MAX = fully open
POS_MID, 100, step index that asserts the middle sensor; must satisfy 0 < POS_MID < POS_MAX
STEP_DIV, 16, clock cycles per motor step (>=2)
DEADTIME, 4, idle cycles enforced on a direction reversal (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
ena  in  1  block enable; low behaves as "no command", position held
subir  in  1  raise command from blind FSM
bajar  in  1  lower command from blind FSM
motor_en  out  1  motor driver enable
dir_out  out  1  1 = up (opening), 0 = down
step_out  out  1  one-cycle step pulse
pos  out  8  current position in steps
s_sup  out  1  upper sensor: pos == POS_MAX
s_med  out  1  middle sensor: pos == POS_MID
s_inf  out  1  lower sensor: pos == 0
fault  out  1  command conflict: subir and bajar both high

Behaviour:
- Reset (rst_n low, async): state IDLE, pos=0, prescaler=0, dead counter=0, motor_en=0, dir_out=0, step_out=0, fault=0. The sensors follow pos, so s_inf=1, s_sup=0, s_med=0.
- Effective command: up = ena & subir & ~bajar; dn = ena & bajar & ~subir.
- fault is registered: set to ena & subir & bajar each cycle. A conflict counts as no command.
- States are IDLE, RUN_UP, RUN_DN and DEAD.
- IDLE:
  - up & pos<POS_MAX -> RUN_UP.
  - dn & pos>0 -> RUN_DN.
  - Otherwise stay. Prescaler cleared.
- RUN_UP / RUN_DN:
  - motor_en=1; dir_out=1 for up, 0 for down.
  - Prescaler counts 0..STEP_DIV-1.
  - On the edge where prescaler==STEP_DIV-1: step_out=1 for one cycle, pos +/-1 on the same edge, prescaler wraps to 0.
  - First step comes STEP_DIV cycles after entering RUN.
- Leaving RUN:
  - Command released (no command, conflict or ena low) -> IDLE next cycle; prescaler cleared; no partial step.
  - Limit: the step that makes pos==POS_MAX (up) or pos==0 (down) also moves state to IDLE on that edge. Commands pushing past a limit are ignored in IDLE.
  - Opposite command -> DEAD, with motor_en=0 and dead counter loaded with DEADTIME-1.
- DEAD:
  - motor_en=0, dir_out keeps its old value.
  - Counts down to 0, then:
    - to the RUN state of the current command if that command is valid and not at its limit;
    - to IDLE if the command is released.
  - A new reversal inside DEAD restarts the count.
- All outputs are registered, except the sensors, which are decoded combinationally from the pos register.
- Width rules: pos is 8 bits, so POS_MAX <= 255. pos never wraps; counting saturates at 0 and POS_MAX.
- Reset mid-run returns pos to 0: the sensors report "closed" after reset, and the system must re-home.

Optional Feature:
Macro SOFT_START_EN.
- Defined: the first 4 steps after each entry into RUN_UP/RUN_DN use a 2*STEP_DIV cycle period, and later steps use STEP_DIV. Needs a 3-bit ramp counter, cleared on leaving RUN.
- Undefined: every step uses STEP_DIV, with no extra logic.

Test Plan:
All scenarios use POS_MAX=8, POS_MID=4, STEP_DIV=4, DEADTIME=3.
1. Reset then subir=1 held: motor_en=1 and dir_out=1 from cycle 1. step_out pulses every 4 cycles. s_med=1 when pos=4. After 8 steps pos=8, s_sup=1, motor_en=0. subir still high produces no further step.
2. From pos=8, bajar=1: dir_out=0. pos decrements 8->0 over 32 cycles, then s_inf=1 and state IDLE. From pos=0, bajar=1 gives motor_en stays 0.
3. At pos=3 running up, switch to bajar: motor_en=0 for exactly 3 cycles. Then RUN_DN; first down step 4 cycles later, pos=2.
4. subir=bajar=1 while at pos=2 running: fault=1 the next cycle, motor_en=0, pos holds at 2. Dropping bajar clears fault and motion resumes upward.
5. ena=0 mid-run at pos=5 keeps pos=5 with no step_out; ena=1 resumes with the prescaler restarted from 0. rst_n low at pos=5 asynchronously gives pos=0 and s_inf=1.
6. With SOFT_START_EN defined and subir from pos=0: step intervals are 8,8,8,8,4,4,4,4 cycles.

Source files
------------

// File: rtl/persiana_actuador.sv
// Step/direction motor front end and blind position plant with limit and middle sensors.
// Optional macro SOFT_START_EN: the first 4 steps of every run use a doubled step period.
module persiana_actuador #(
    parameter int unsigned POS_MAX  = 200,
    parameter int unsigned POS_MID  = 100,
    parameter int unsigned STEP_DIV = 16,
    parameter int unsigned DEADTIME = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       subir,
    input  logic       bajar,
    output logic       motor_en,
    output logic       dir_out,
    output logic       step_out,
    output logic [7:0] pos,
    output logic       s_sup,
    output logic       s_med,
    output logic       s_inf,
    output logic       fault
);

    localparam int unsigned PW = $clog2(2 * STEP_DIV);
    localparam int unsigned DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

    localparam logic [7:0]    P_MAX     = 8'(POS_MAX);
    localparam logic [7:0]    P_MAX_M1  = 8'(POS_MAX - 1);
    localparam logic [7:0]    P_MID     = 8'(POS_MID);
    localparam logic [PW-1:0] PRE_LAST  = PW'(STEP_DIV - 1);
    localparam logic [DW-1:0] DEAD_INIT = DW'(DEADTIME - 1);

    typedef enum logic [1:0] {StIdle, StRunUp, StRunDn, StDead} state_t;

    state_t        r_state;
    logic [7:0]    r_pos;
    logic [PW-1:0] r_pre;
    logic [DW-1:0] r_dead;
    logic          r_dead_up;
    logic          r_motor_en;
    logic          r_dir;
    logic          r_step;
    logic          r_fault;

    logic w_up;
    logic w_dn;
    logic w_in_run;
    logic w_fwd;
    logic w_rev;
    logic w_pre_last;
    logic w_at_max;
    logic w_at_min;

    assign w_up     = ena & subir & ~bajar;
    assign w_dn     = ena & bajar & ~subir;
    assign w_at_max = (r_pos == P_MAX);
    assign w_at_min = (r_pos == 8'd0);
    assign w_in_run = (r_state == StRunUp) || (r_state == StRunDn);
    // Command along / against the direction of the current run.
    assign w_fwd    = (r_state == StRunUp) ? w_up : w_dn;
    assign w_rev    = (r_state == StRunUp) ? w_dn : w_up;

`ifdef SOFT_START_EN
    localparam logic [PW-1:0] PRE_SLOW_LAST = PW'(2 * STEP_DIV - 1);

    logic [2:0] r_ramp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ramp <= '0;
        end else if (!w_in_run) begin
            r_ramp <= '0;
        end else if (w_fwd && w_pre_last && (r_ramp != 3'd4)) begin
            r_ramp <= r_ramp + 3'd1;
        end
    end

    assign w_pre_last = (r_pre == ((r_ramp < 3'd4) ? PRE_SLOW_LAST : PRE_LAST));
`else
    assign w_pre_last = (r_pre == PRE_LAST);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_pos      <= '0;
            r_pre      <= '0;
            r_dead     <= '0;
            r_dead_up  <= 1'b0;
            r_motor_en <= 1'b0;
            r_dir      <= 1'b0;
            r_step     <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_fault <= ena & subir & bajar;
            r_step  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_pre <= '0;
                    if (w_up && !w_at_max) begin
                        r_state    <= StRunUp;
                        r_motor_en <= 1'b1;
                        r_dir      <= 1'b1;
                    end else if (w_dn && !w_at_min) begin
                        r_state    <= StRunDn;
                        r_motor_en <= 1'b1;
                        r_dir      <= 1'b0;
                    end
                end
                StRunUp, StRunDn: begin
                    if (w_rev) begin
                        r_state    <= StDead;
                        r_motor_en <= 1'b0;
                        r_pre      <= '0;
                        r_dead     <= DEAD_INIT;
                        r_dead_up  <= (r_state == StRunDn);
                    end else if (!w_fwd) begin
                        r_state    <= StIdle;
                        r_motor_en <= 1'b0;
                        r_pre      <= '0;
                    end else if (w_pre_last) begin
                        r_pre  <= '0;
                        r_step <= 1'b1;
                        if (r_state == StRunUp) begin
                            r_pos <= r_pos + 8'd1;
                            if (r_pos == P_MAX_M1) begin
                                r_state    <= StIdle;
                                r_motor_en <= 1'b0;
                            end
                        end else begin
                            r_pos <= r_pos - 8'd1;
                            if (r_pos == 8'd1) begin
                                r_state    <= StIdle;
                                r_motor_en <= 1'b0;
                            end
                        end
                    end else begin
                        r_pre <= r_pre + 1'b1;
                    end
                end
                StDead: begin
                    r_pre <= '0;
                    // A reversal against the pending direction restarts the dead time.
                    if ((w_up && !r_dead_up) || (w_dn && r_dead_up)) begin
                        r_dead    <= DEAD_INIT;
                        r_dead_up <= w_up;
                    end else if (r_dead != '0) begin
                        r_dead <= r_dead - 1'b1;
                    end else if (w_up && !w_at_max) begin
                        r_state    <= StRunUp;
                        r_motor_en <= 1'b1;
                        r_dir      <= 1'b1;
                    end else if (w_dn && !w_at_min) begin
                        r_state    <= StRunDn;
                        r_motor_en <= 1'b1;
                        r_dir      <= 1'b0;
                    end else begin
                        r_state <= StIdle;
                    end
                end
            endcase
        end
    end

    assign motor_en = r_motor_en;
    assign dir_out  = r_dir;
    assign step_out = r_step;
    assign pos      = r_pos;
    assign fault    = r_fault;
    assign s_sup    = (r_pos == P_MAX);
    assign s_med    = (r_pos == P_MID);
    assign s_inf    = (r_pos == 8'd0);

endmodule
